dmem_latency_model: RTL and testbench

//  Behavioural data-memory slave for the CPU_RV32IM dmem port, used in the top-level CPU bench.

---
 rtl/dmem_model_pkg.sv | 20 ++
 rtl/dmem_latency_model_if.sv | 20 ++
 rtl/dmem_resp_fifo.sv | 45 ++++
 rtl/dmem_latency_model.sv | 118 +++++++++++
 tb/tb_dmem_latency_model.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_model_pkg.sv
// Shared types and helpers for the queued data-memory latency model.
package dmem_model_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } dmem_entry_t;

  localparam logic [31:0] OOB_DATA = 32'hDEADBEEF;

  function automatic logic [31:0] addr_to_idx(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // x^8 + x^6 + x^5 + x^4 + 1, maximal length from any non-zero seed
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/dmem_latency_model_if.sv
// CPU dmem request/response bus: valid/ready requests, unacknowledged load-response pulses.
interface dmem_latency_model_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/dmem_resp_fifo.sv
// In-order queue of pending load responses; head is visible combinationally.
// Caller guarantees no push when full and no pop when empty.
module dmem_resp_fifo
  import dmem_model_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  dmem_entry_t      push_data,
  input  logic             pop,
  output dmem_entry_t      head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  dmem_entry_t      slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head  = slots[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_latency_model.sv
// Behavioural dmem slave: loads answered in order after LOAD_LATENCY(+jitter) edges,
// req_ready drops when the response queue is full or on a periodic stall slot.
module dmem_latency_model
  import dmem_model_pkg::*;
#(
  parameter int          MEM_SIZE_WORDS  = 16384,
  parameter int          LOAD_LATENCY    = 1,
  parameter logic [7:0]  LAT_JITTER_MASK = 8'h00,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          STALL_PERIOD    = 0,
  parameter logic [31:0] TOHOST_ADDR     = 32'h0000_1000,
  localparam int         CNT_W           = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_latency_model_if.slave  bus,
  input  logic                 bd_we,
  input  logic [31:0]          bd_addr,
  input  logic [31:0]          bd_data,
  output logic                 tohost_valid,
  output logic [31:0]          tohost_data,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 err_oob
);

  localparam int IDX_W = $clog2(MEM_SIZE_WORDS);

  logic [31:0]      mem [MEM_SIZE_WORDS];
  logic [31:0]      stamp;
  logic [7:0]       lfsr;
  logic [31:0]      stall_cnt;
  logic [31:0]      stall_cnt_next;
  logic             stall_slot_next;
  logic             accept;
  logic             ld_acc;
  logic             st_acc;
  logic             req_oob;
  logic             is_tohost;
  logic [31:0]      req_idx;
  logic [31:0]      ld_data;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] count_next;
  dmem_entry_t      push_entry;
  dmem_entry_t      head;

  assign accept    = bus.req_valid & bus.req_ready;
  assign ld_acc    = accept & ~bus.req_we;
  assign st_acc    = accept & bus.req_we;
  assign req_idx   = addr_to_idx(bus.req_addr);
  assign req_oob   = (req_idx >= MEM_SIZE_WORDS);
  assign is_tohost = ({bus.req_addr[31:2], 2'b00} == TOHOST_ADDR);

  // Read-at-accept: a store accepted later never changes an already queued load.
  assign ld_data    = req_oob ? OOB_DATA : mem[req_idx[IDX_W-1:0]];
  assign push_entry = '{data: ld_data,
                        due:  stamp + 32'(LOAD_LATENCY) + {24'h0, lfsr & LAT_JITTER_MASK}};
  assign push       = ld_acc & ~fifo_full;

  // Signed difference keeps the due check correct across stamp wrap.
  assign pop        = ~fifo_empty & ($signed(head.due - stamp) <= 0);
  assign count_next = outstanding + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    stall_cnt_next  = '0;
    stall_slot_next = 1'b0;
    if (STALL_PERIOD > 0) begin
      stall_cnt_next  = (stall_cnt == 32'(STALL_PERIOD - 1)) ? '0 : stall_cnt + 32'd1;
      stall_slot_next = (stall_cnt_next == 32'(STALL_PERIOD - 1));
    end
  end

  dmem_resp_fifo #(.DEPTH(QUEUE_DEPTH)) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (outstanding),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stamp          <= '0;
      lfsr           <= 8'h01;
      stall_cnt      <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      tohost_valid   <= 1'b0;
      tohost_data    <= '0;
      err_oob        <= 1'b0;
    end else begin
      stamp          <= stamp + 32'd1;
      stall_cnt      <= stall_cnt_next;
      // No bypass: a pop in a full cycle only reopens ready for the next cycle.
      bus.req_ready  <= (count_next < CNT_W'(QUEUE_DEPTH)) & ~stall_slot_next;
      bus.resp_valid <= pop;
      if (pop)              bus.resp_data <= head.data;
      if (ld_acc)           lfsr          <= lfsr_step(lfsr);
      tohost_valid   <= st_acc & is_tohost;
      if (st_acc & is_tohost) tohost_data <= bus.req_data;
      if (accept & req_oob) err_oob       <= 1'b1;
    end
  end

  // Request store is written last so it wins over a same-edge backdoor write.
  always_ff @(posedge clock) begin
    if (bd_we && (bd_addr < MEM_SIZE_WORDS)) mem[bd_addr[IDX_W-1:0]] <= bd_data;
    if (st_acc && !req_oob)                  mem[req_idx[IDX_W-1:0]] <= bus.req_data;
  end

endmodule

// File: tb/tb_dmem_latency_model.sv
// Directed bench for dmem_latency_model: three configurations checked against a response scoreboard.
module tb_dmem_latency_model;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_latency_model_if bus_a ();
  dmem_latency_model_if bus_b ();
  dmem_latency_model_if bus_c ();

  logic        rv [3];
  logic        rwe [3];
  logic [31:0] radr [3];
  logic [31:0] rdat [3];
  logic        rdy [3];
  logic        rsp_v [3];
  logic [31:0] rsp_d [3];
  logic        th_v [3];
  logic [31:0] th_d [3];
  logic [2:0]  outs [3];
  logic        oob [3];
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  assign bus_a.req_valid = rv[0];
  assign bus_a.req_we    = rwe[0];
  assign bus_a.req_addr  = radr[0];
  assign bus_a.req_data  = rdat[0];
  assign rdy[0]   = bus_a.req_ready;
  assign rsp_v[0] = bus_a.resp_valid;
  assign rsp_d[0] = bus_a.resp_data;
  assign bus_b.req_valid = rv[1];
  assign bus_b.req_we    = rwe[1];
  assign bus_b.req_addr  = radr[1];
  assign bus_b.req_data  = rdat[1];
  assign rdy[1]   = bus_b.req_ready;
  assign rsp_v[1] = bus_b.resp_valid;
  assign rsp_d[1] = bus_b.resp_data;
  assign bus_c.req_valid = rv[2];
  assign bus_c.req_we    = rwe[2];
  assign bus_c.req_addr  = radr[2];
  assign bus_c.req_data  = rdat[2];
  assign rdy[2]   = bus_c.req_ready;
  assign rsp_v[2] = bus_c.resp_valid;
  assign rsp_d[2] = bus_c.resp_data;

  dmem_latency_model u_a (
    .clock(clock), .reset(reset), .bus(bus_a),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
    .tohost_valid(th_v[0]), .tohost_data(th_d[0]), .outstanding(outs[0]), .err_oob(oob[0])
  );

  dmem_latency_model #(.LOAD_LATENCY(3), .LAT_JITTER_MASK(8'h07)) u_b (
    .clock(clock), .reset(reset), .bus(bus_b),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
    .tohost_valid(th_v[1]), .tohost_data(th_d[1]), .outstanding(outs[1]), .err_oob(oob[1])
  );

  dmem_latency_model #(.STALL_PERIOD(7)) u_c (
    .clock(clock), .reset(reset), .bus(bus_c),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
    .tohost_valid(th_v[2]), .tohost_data(th_d[2]), .outstanding(outs[2]), .err_oob(oob[2])
  );

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          resp_cnt [2] = '{0, 0};
  bit          saw_full = 1'b0;
  logic [31:0] shadow [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every response pulse pops the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    int   lat;
    if (rsp_v[0] === 1'b1) begin
      resp_cnt[0]++;
      check("a_resp_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e   = q0.pop_front();
        lat = cyc - e.acc;
        check("a_resp_data", rsp_d[0], e.data);
        check("a_resp_latency", 32'(lat), 32'd1);
      end
    end
    if (rsp_v[1] === 1'b1) begin
      resp_cnt[1]++;
      check("b_resp_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e   = q1.pop_front();
        lat = cyc - e.acc;
        check("b_resp_data", rsp_d[1], e.data);
        check("b_latency_in_3_to_10", 32'(lat >= 3 && lat <= 10), 32'd1);
      end
    end
    if (outs[1] == 3'd4) begin
      saw_full = 1'b1;
      check("b_ready_low_when_full", 32'(rdy[1]), 32'd0);
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp);
    bit done = 1'b0;
    rv[d] = 1'b1; rwe[d] = we; radr[d] = addr; rdat[d] = data;
    for (int i = 0; i < 50 && !done; i++) begin
      if (rdy[d]) begin
        done = 1'b1;
        if (!we && d == 0) q0.push_back('{data: exp, acc: cyc + 1});
        if (!we && d == 1) q1.push_back('{data: exp, acc: cyc + 1});
      end
      @(negedge clock);
    end
    rv[d] = 1'b0;
    check("req_accepted_in_budget", 32'(done), 32'd1);
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 200; i++) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) break;
      @(negedge clock);
    end
    check(d == 0 ? "a_drained" : "b_drained", 32'(d == 0 ? q0.size() : q1.size()), 32'd0);
    check(d == 0 ? "a_outs_zero" : "b_outs_zero", 32'(outs[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int rc;
    int lows;
    int w;
    for (int d = 0; d < 3; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; radr[d] = '0; rdat[d] = '0;
    end
    @(negedge clock);
    check("rst_req_ready", 32'(rdy[0]), 32'd0);
    check("rst_resp_valid", 32'(rsp_v[0]), 32'd0);
    check("rst_resp_data", rsp_d[0], 32'd0);
    check("rst_tohost_valid", 32'(th_v[0]), 32'd0);
    check("rst_tohost_data", th_d[0], 32'd0);
    check("rst_outstanding", 32'(outs[0]), 32'd0);
    check("rst_err_oob", 32'(oob[0]), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) begin
      bd_we = 1'b1; bd_addr = i;
      bd_data = (i == 5) ? 32'h1234_5678 : (32'hA500_0000 | (i << 8) | i);
      shadow[i] = bd_data;
      @(negedge clock);
    end
    bd_we = 1'b0;

    // Single load, latency 1: pulse exactly one cycle after the accepting edge
    do_req(0, 1'b0, 32'h14, 32'h0, 32'h1234_5678);
    check("t1_no_resp_at_accept", 32'(rsp_v[0]), 32'd0);
    @(negedge clock);
    check("t1_resp_valid", 32'(rsp_v[0]), 32'd1);
    check("t1_resp_data", rsp_d[0], 32'h1234_5678);
    @(negedge clock);
    check("t1_resp_one_cycle", 32'(rsp_v[0]), 32'd0);

    // Load then store same word: load sees the old value
    do_req(0, 1'b0, 32'h40, 32'h0, shadow[16]);
    do_req(0, 1'b1, 32'h40, 32'hAAAA_AAAA, 32'h0);
    shadow[16] = 32'hAAAA_AAAA;
    do_req(0, 1'b0, 32'h40, 32'h0, shadow[16]);
    drain(0);

    // tohost and out-of-range handling
    do_req(0, 1'b1, 32'h1000, 32'h1, 32'h0);
    check("t5_tohost_valid", 32'(th_v[0]), 32'd1);
    check("t5_tohost_data", th_d[0], 32'd1);
    @(negedge clock);
    check("t5_tohost_one_cycle", 32'(th_v[0]), 32'd0);
    check("t5_oob_clear", 32'(oob[0]), 32'd0);
    do_req(0, 1'b1, 32'h0004_0000, 32'h55, 32'h0);
    check("t5_oob_set", 32'(oob[0]), 32'd1);
    repeat (3) @(negedge clock);
    check("t5_oob_sticky", 32'(oob[0]), 32'd1);
    do_req(0, 1'b0, 32'h0004_0000, 32'h0, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 32'h1000, 32'h0, 32'h1);
    drain(0);

    // Back-to-back loads into the latency-3, jittered model: queue fills, order kept
    for (int i = 1; i <= 5; i++) do_req(1, 1'b0, i * 4, 32'h0, shadow[i]);
    drain(1);
    check("t2_queue_filled", 32'(saw_full), 32'd1);

    for (int i = 0; i < 64; i++) begin
      w = $urandom_range(63, 0);
      do_req(1, 1'b0, w * 4, 32'h0, shadow[w]);
      repeat ($urandom_range(2, 0)) @(negedge clock);
    end
    drain(1);

    // Reset with loads in flight: nothing answered afterwards, memory kept
    for (int i = 0; i < 3; i++) do_req(1, 1'b0, (i + 8) * 4, 32'h0, shadow[i + 8]);
    check("t6_outs_before_reset", 32'(outs[1]), 32'd3);
    rc = resp_cnt[1];
    reset = 1'b1;
    q1.delete();
    #1;
    check("t6_outs_reset", 32'(outs[1]), 32'd0);
    check("t6_resp_valid_reset", 32'(rsp_v[1]), 32'd0);
    check("t6_ready_reset", 32'(rdy[1]), 32'd0);
    check("t6_oob_reset", 32'(oob[0]), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("t6_no_stale_resp", 32'(resp_cnt[1] - rc), 32'd0);
    do_req(0, 1'b0, 32'h14, 32'h0, 32'h1234_5678);
    do_req(0, 1'b0, 32'h40, 32'h0, 32'hAAAA_AAAA);
    do_req(0, 1'b0, 32'h1000, 32'h0, 32'h1);
    do_req(1, 1'b0, 32'h1C, 32'h0, shadow[7]);
    drain(0);
    drain(1);

    // Stall period 7 on an idle model: ready low one cycle in every seven
    lows = 0;
    for (int i = 0; i < 70; i++) begin
      if (!rdy[2]) lows++;
      @(negedge clock);
    end
    check("stall_low_cycles", 32'(lows), 32'd10);
    check("stall_outs_zero", 32'(outs[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
